// File: rtl/enemy_bullet_ctrl_if.sv
// Engine-side bundle for the enemy bullet controller: shot requests, formation
// and player geometry in, bullet slots and player status out.
interface enemy_bullet_ctrl_if #(
  parameter int N_ENEMY = 24,
  parameter int N_SLOTS = 4
);
  logic                   restart;
  logic [5:0]             ID_enemy_tiro;
  logic [N_ENEMY-1:0]     enemy_vivos;
  logic [9:0]             form_x;
  logic [9:0]             form_y;
  logic [9:0]             player_x;
  logic                   move_tick;
  logic [N_SLOTS-1:0]     bullet_valid;
  logic [10*N_SLOTS-1:0]  bullet_x;
  logic [10*N_SLOTS-1:0]  bullet_y;
  logic                   jogador_vivo;
  logic                   player_hit;
  logic                   shot_dropped;

  modport master (
    output restart, ID_enemy_tiro, enemy_vivos, form_x, form_y, player_x, move_tick,
    input  bullet_valid, bullet_x, bullet_y, jogador_vivo, player_hit, shot_dropped
  );

  modport slave (
    input  restart, ID_enemy_tiro, enemy_vivos, form_x, form_y, player_x, move_tick,
    output bullet_valid, bullet_x, bullet_y, jogador_vivo, player_hit, shot_dropped
  );
endinterface

// File: rtl/enemy_bullet_ctrl.sv
// Enemy bullet pool: spawns bullets under the shooting enemy, moves them down
// the screen, and detects the single hit that kills the player.
module enemy_bullet_ctrl #(
  parameter int N_ENEMY   = 24,
  parameter int N_SLOTS   = 4,
  parameter int COLS      = 8,
  parameter int COL_PITCH = 40,
  parameter int ROW_PITCH = 32,
  parameter int ENEMY_W   = 32,
  parameter int ENEMY_H   = 24,
  parameter int STEP      = 4,
  parameter int SCREEN_H  = 480,
  parameter int PLAYER_Y  = 440,
  parameter int PLAYER_W  = 32,
  parameter int PLAYER_H  = 16
) (
  input  logic              clk,
  input  logic              reset,
  enemy_bullet_ctrl_if.slave bus
);

  localparam int         IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [5:0] ID_NONE = 6'(N_ENEMY);

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  slot_t      slot_q [N_SLOTS];
  slot_t      slot_d [N_SLOTS];
  logic [5:0] id_prev_q, id_prev_d;
  logic       alive_q, alive_d;
  logic       hit_q, hit_d;
  logic       drop_q, drop_d;

  logic [N_ENEMY-1:0] alive_shift;
  logic               enemy_alive;
  logic               request;
  logic               accept;
  logic               all_full;
  logic [IDX_W-1:0]   free_idx;
  logic [5:0]         col;
  logic [5:0]         row;
  logic [9:0]         spawn_x;
  logic [9:0]         spawn_y;
  logic [N_SLOTS-1:0] hit_vec;

  // Request decode and spawn geometry for the current shooter.
  always_comb begin
    alive_shift = bus.enemy_vivos >> bus.ID_enemy_tiro;
    enemy_alive = alive_shift[0];
    request     = (bus.ID_enemy_tiro < ID_NONE) && (bus.ID_enemy_tiro != id_prev_q);
    accept      = request && enemy_alive && alive_q;
    col         = bus.ID_enemy_tiro % 6'(COLS);
    row         = bus.ID_enemy_tiro / 6'(COLS);
    spawn_x     = bus.form_x + 10'(col) * 10'(COL_PITCH) + 10'(ENEMY_W / 2);
    spawn_y     = bus.form_y + 10'(row) * 10'(ROW_PITCH) + 10'(ENEMY_H);
  end

  // Lowest free slot, judged on registered state so a slot freed this cycle is not reused.
  always_comb begin
    all_full = 1'b1;
    free_idx = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!slot_q[k].valid) begin
        all_full = 1'b0;
        free_idx = IDX_W'(k);
      end
    end
  end

  // Hit test on registered positions; 11-bit compares keep the player box from wrapping.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      hit_vec[k] = alive_q && slot_q[k].valid
                && ({1'b0, slot_q[k].x} >= {1'b0, bus.player_x})
                && ({1'b0, slot_q[k].x} <  {1'b0, bus.player_x} + 11'(PLAYER_W))
                && ({1'b0, slot_q[k].y} >= 11'(PLAYER_Y))
                && ({1'b0, slot_q[k].y} <  11'(PLAYER_Y + PLAYER_H));
    end
  end

  // NOTE: next state is computed here with blocking assignments and defaults first
  // (no latches); the register process below only copies it with non-blocking <=.
  always_comb begin
    id_prev_d = bus.ID_enemy_tiro;
    alive_d   = alive_q && !(|hit_vec);
    hit_d     = |hit_vec;
    drop_d    = accept && all_full;
    for (int k = 0; k < N_SLOTS; k++) begin
      slot_d[k] = slot_q[k];
      if (hit_vec[k]) begin
        slot_d[k].valid = 1'b0;
      end else if (bus.move_tick && slot_q[k].valid) begin
        if ({1'b0, slot_q[k].y} + 11'(STEP) >= 11'(SCREEN_H)) begin
          slot_d[k].valid = 1'b0;
        end else begin
          slot_d[k].y = slot_q[k].y + 10'(STEP);
        end
      end
      if (accept && !all_full && (free_idx == IDX_W'(k))) begin
        slot_d[k].valid = 1'b1;
        slot_d[k].x     = spawn_x;
        slot_d[k].y     = spawn_y;
      end
    end
    if (bus.restart) begin
      id_prev_d = ID_NONE;
      alive_d   = 1'b1;
      hit_d     = 1'b0;
      drop_d    = 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        slot_d[k] = '0;
      end
    end
  end

  // NOTE: the slot array is a handful of flops, not a RAM, so it is reset like any
  // other state; that is what lets a reset discard bullets in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_prev_q <= ID_NONE;
      alive_q   <= 1'b1;
      hit_q     <= 1'b0;
      drop_q    <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      id_prev_q <= id_prev_d;
      alive_q   <= alive_d;
      hit_q     <= hit_d;
      drop_q    <= drop_d;
      for (int k = 0; k < N_SLOTS; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  logic [N_SLOTS-1:0]    valid_vec;
  logic [10*N_SLOTS-1:0] x_vec;
  logic [10*N_SLOTS-1:0] y_vec;

  always_comb begin
    valid_vec = '0;
    x_vec     = '0;
    y_vec     = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      valid_vec[k]       = slot_q[k].valid;
      x_vec[10*k +: 10]  = slot_q[k].x;
      y_vec[10*k +: 10]  = slot_q[k].y;
    end
  end

  assign bus.bullet_valid = valid_vec;
  assign bus.bullet_x     = x_vec;
  assign bus.bullet_y     = y_vec;
  assign bus.jogador_vivo = alive_q;
  assign bus.player_hit   = hit_q;
  assign bus.shot_dropped = drop_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Directed bench for enemy_bullet_ctrl: spawn geometry, slot exhaustion, motion
// and screen exit, hit detection, restart and asynchronous reset.
module tb_enemy_bullet_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  enemy_bullet_ctrl_if #(.N_ENEMY(24), .N_SLOTS(4)) bus ();

  enemy_bullet_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    bus.ID_enemy_tiro = 6'd24;
    bus.move_tick     = 1'b0;
    bus.restart       = 1'b1;
    step();
    bus.restart       = 1'b0;
  endtask

  initial begin
    bus.restart       = 1'b0;
    bus.ID_enemy_tiro = 6'd24;
    bus.enemy_vivos   = '1;
    bus.form_x        = 10'd0;
    bus.form_y        = 10'd0;
    bus.player_x      = 10'd100;
    bus.move_tick     = 1'b0;

    // Asynchronous reset before any clock edge
    #3 reset = 1'b0;
    #1;
    check("rst_valid", 64'(bus.bullet_valid), 64'd0);
    check("rst_x", 64'(bus.bullet_x), 64'd0);
    check("rst_y", 64'(bus.bullet_y), 64'd0);
    check("rst_alive", 64'(bus.jogador_vivo), 64'd1);
    check("rst_hit", 64'(bus.player_hit), 64'd0);
    check("rst_drop", 64'(bus.shot_dropped), 64'd0);
    step();
    step();
    reset = 1'b1;

    // Enemy 9 fires from the origin formation: col 1, row 1
    bus.ID_enemy_tiro = 6'd9;
    step();
    check("spawn9_valid", 64'(bus.bullet_valid), 64'b0001);
    check("spawn9_x", 64'(bus.bullet_x[9:0]), 64'd56);
    check("spawn9_y", 64'(bus.bullet_y[9:0]), 64'd56);

    // Held ID is one request only
    repeat (100) step();
    check("hold9_valid", 64'(bus.bullet_valid), 64'b0001);

    // Dead shooter is ignored
    bus.ID_enemy_tiro = 6'd24;
    bus.enemy_vivos[9] = 1'b0;
    step();
    bus.ID_enemy_tiro = 6'd9;
    step();
    check("dead9_valid", 64'(bus.bullet_valid), 64'b0001);
    bus.enemy_vivos[9] = 1'b1;

    // Fill remaining slots, fifth request is dropped
    bus.ID_enemy_tiro = 6'd1;  step();
    bus.ID_enemy_tiro = 6'd2;  step();
    bus.ID_enemy_tiro = 6'd3;  step();
    check("fill_valid", 64'(bus.bullet_valid), 64'b1111);
    check("fill_drop_idle", 64'(bus.shot_dropped), 64'd0);
    bus.ID_enemy_tiro = 6'd17; step();
    check("drop_pulse", 64'(bus.shot_dropped), 64'd1);
    check("drop_valid", 64'(bus.bullet_valid), 64'b1111);
    check("drop_x", 64'(bus.bullet_x), {24'd0, 10'd136, 10'd96, 10'd56, 10'd56});
    check("drop_y", 64'(bus.bullet_y), {24'd0, 10'd24, 10'd24, 10'd24, 10'd56});
    bus.ID_enemy_tiro = 6'd24; step();
    check("drop_one_cycle", 64'(bus.shot_dropped), 64'd0);

    do_restart();
    check("restart_valid", 64'(bus.bullet_valid), 64'd0);
    check("restart_alive", 64'(bus.jogador_vivo), 64'd1);

    // Bottom edge: 472 steps to 476, then exits; freed slot not reused by a same-cycle spawn
    bus.form_x = 10'd0;
    bus.form_y = 10'd448;
    bus.ID_enemy_tiro = 6'd0;
    step();
    check("edge_spawn_y", 64'(bus.bullet_y[9:0]), 64'd472);
    bus.move_tick = 1'b1;
    step();
    check("edge_476_y", 64'(bus.bullet_y[9:0]), 64'd476);
    check("edge_476_valid", 64'(bus.bullet_valid), 64'b0001);
    bus.ID_enemy_tiro = 6'd1;
    step();
    check("edge_exit_valid", 64'(bus.bullet_valid), 64'b0010);
    check("edge_spawn_unstepped_y", 64'(bus.bullet_y[19:10]), 64'd472);
    check("edge_spawn_x", 64'(bus.bullet_x[19:10]), 64'd56);
    bus.move_tick = 1'b0;
    do_restart();

    // Player hit: slot0 at (110,436), slot1 at (110,428)
    bus.form_x = 10'd94;
    bus.form_y = 10'd412;
    bus.ID_enemy_tiro = 6'd0;
    step();
    bus.form_x = 10'd54;
    bus.form_y = 10'd404;
    bus.ID_enemy_tiro = 6'd1;
    step();
    check("hit_setup_x", 64'(bus.bullet_x[19:0]), {10'd110, 10'd110});
    check("hit_setup_y", 64'(bus.bullet_y[19:0]), {10'd428, 10'd436});
    bus.move_tick = 1'b1;
    step();
    bus.move_tick = 1'b0;
    check("hit_overlap_no_pulse_yet", 64'(bus.player_hit), 64'd0);
    check("hit_overlap_y0", 64'(bus.bullet_y[9:0]), 64'd440);
    step();
    check("hit_pulse", 64'(bus.player_hit), 64'd1);
    check("hit_alive", 64'(bus.jogador_vivo), 64'd0);
    check("hit_slot_cleared", 64'(bus.bullet_valid), 64'b0010);
    step();
    check("hit_pulse_ends", 64'(bus.player_hit), 64'd0);
    bus.move_tick = 1'b1;
    step();
    step();
    bus.move_tick = 1'b0;
    step();
    check("dead_overlap_no_pulse", 64'(bus.player_hit), 64'd0);
    check("dead_overlap_valid", 64'(bus.bullet_valid), 64'b0010);
    check("dead_overlap_y1", 64'(bus.bullet_y[19:10]), 64'd440);
    check("dead_alive", 64'(bus.jogador_vivo), 64'd0);
    bus.ID_enemy_tiro = 6'd2;
    step();
    check("dead_no_spawn", 64'(bus.bullet_valid), 64'b0010);

    // Restart mid-flight, then asynchronous reset mid-flight
    do_restart();
    check("restart2_valid", 64'(bus.bullet_valid), 64'd0);
    check("restart2_alive", 64'(bus.jogador_vivo), 64'd1);
    bus.form_x = 10'd0;
    bus.form_y = 10'd0;
    bus.ID_enemy_tiro = 6'd5;
    step();
    check("flight_x", 64'(bus.bullet_x[9:0]), 64'd216);
    check("flight_y", 64'(bus.bullet_y[9:0]), 64'd24);
    #2 reset = 1'b0;
    #1;
    check("async_valid", 64'(bus.bullet_valid), 64'd0);
    check("async_x", 64'(bus.bullet_x), 64'd0);
    check("async_y", 64'(bus.bullet_y), 64'd0);
    check("async_alive", 64'(bus.jogador_vivo), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    check("async_held_valid", 64'(bus.bullet_valid), 64'd0);
    reset = 1'b1;
    step();
    check("post_reset_respawn_valid", 64'(bus.bullet_valid), 64'b0001);
    check("post_reset_respawn_x", 64'(bus.bullet_x[9:0]), 64'd216);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
